superscalar_perf_monitor: RTL and testbench

In-hardware performance monitor for the dual-issue pipeline. Each cycle it counts cycles, issued instructions, resolved branches and jumps, and branch and jump mispredictions from both issue slots. It detects program completion, which is both fetch slots parked on a self-looping NOP, and freezes all counts at that point. A registered read port exposes the counts to the system side, so completion and CPI data come from the datapath itself rather than from bench-side probing.

---
 rtl/superscalar_perf_monitor_pkg.sv | 30 +++
 rtl/superscalar_perf_monitor_if.sv | 40 ++++
 rtl/superscalar_perf_monitor_perf_counter.sv | 49 ++++
 rtl/superscalar_perf_monitor.sv | 124 ++++++++++++
 tb/tb_superscalar_perf_monitor.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/superscalar_perf_monitor_pkg.sv
// Shared constants for the dual-issue performance monitor: counter map, opcodes, NOP encoding.
// Pure declarations; no logic, no latency.
package superscalar_perf_monitor_pkg;

  localparam int CNT_CYCLES   = 0;
  localparam int CNT_INSTRS   = 1;
  localparam int CNT_BRANCHES = 2;
  localparam int CNT_BR_MISS  = 3;
  localparam int CNT_JUMPS    = 4;
  localparam int CNT_JMP_MISS = 5;
  localparam int CNT_STATUS   = 6;
  localparam int NUM_CNT      = 6;
  localparam int RD_ADDR_W    = 3;

  localparam logic [6:0]  OP_BRANCH    = 7'b1100011;
  localparam logic [6:0]  OP_JAL       = 7'b1101111;
  localparam logic [6:0]  OP_JALR      = 7'b1100111;
  localparam logic [31:0] NOP_WORD_DEF = 32'h0000_0013;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } state_e;

  // Population count of two slot flags: 0, 1 or 2.
  function automatic logic [1:0] count2(input logic a, input logic b);
    return {a & b, a ^ b};
  endfunction

endpackage

// File: rtl/superscalar_perf_monitor_if.sv
// Pipeline tap and counter read port of the performance monitor.
// Read port is fire-and-forget: rd_req is always accepted, data returns one cycle later.
interface superscalar_perf_monitor_if
  import superscalar_perf_monitor_pkg::*;
#(
  parameter int WIDTH = 32
);
  logic                 en;
  logic                 clr;
  logic [31:0]          instr_d1;
  logic [31:0]          instr_d2;
  logic [6:0]           op_e1;
  logic [6:0]           op_e2;
  logic                 mispredict1;
  logic                 mispredict2;
  logic                 pred_taken1;
  logic                 pred_taken2;
  logic [31:0]          pc_f1;
  logic [31:0]          pc_f2;
  logic [31:0]          instr_f1;
  logic [31:0]          instr_f2;
  logic                 rd_req;
  logic [RD_ADDR_W-1:0] rd_addr;
  logic                 rd_valid;
  logic [WIDTH-1:0]     rd_data;
  logic                 halted;

  modport master (
    output en, clr, instr_d1, instr_d2, op_e1, op_e2, mispredict1, mispredict2,
           pred_taken1, pred_taken2, pc_f1, pc_f2, instr_f1, instr_f2, rd_req, rd_addr,
    input  rd_valid, rd_data, halted
  );

  modport slave (
    input  en, clr, instr_d1, instr_d2, op_e1, op_e2, mispredict1, mispredict2,
           pred_taken1, pred_taken2, pc_f1, pc_f2, instr_f1, instr_f2, rd_req, rd_addr,
    output rd_valid, rd_data, halted
  );

endinterface

// File: rtl/superscalar_perf_monitor_perf_counter.sv
// One event counter with 0..2 increment and sticky overflow; updates on the edge after inputs.
// PERF_SATURATE_EN defined: clamp at all-ones; undefined: wrap modulo 2^WIDTH.
module perf_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             clr,
  input  logic [1:0]       inc,
  output logic [WIDTH-1:0] cnt,
  output logic             ovf
);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH:0]   sum;

  always_comb begin
    sum   = {1'b0, cnt_q} + {{(WIDTH - 1){1'b0}}, inc};
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (clr) begin
      cnt_d = '0;
      ovf_d = 1'b0;
    end else if (en) begin
      ovf_d = ovf_q | sum[WIDTH];
`ifdef PERF_SATURATE_EN
      cnt_d = sum[WIDTH] ? {WIDTH{1'b1}} : sum[WIDTH-1:0];
`else
      cnt_d = sum[WIDTH-1:0];
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  assign cnt = cnt_q;
  assign ovf = ovf_q;

endmodule

// File: rtl/superscalar_perf_monitor.sv
// Dual-issue perf monitor: six event counters, parked-NOP halt detection, 1-cycle registered read.
// Reads always accepted (one per cycle); PERF_SATURATE_EN selects saturating counters.
module superscalar_perf_monitor
  import superscalar_perf_monitor_pkg::*;
#(
  parameter int          WIDTH    = 32,
  parameter logic [31:0] NOP_WORD = NOP_WORD_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  superscalar_perf_monitor_if.slave bus
);

  state_e           state_q, state_d;
  logic             prev_valid_q, prev_valid_d;
  logic [31:0]      prev_pc1_q, prev_pc1_d, prev_pc2_q, prev_pc2_d;
  logic             rd_valid_q, rd_valid_d;
  logic [WIDTH-1:0] rd_data_q, rd_data_d;

  logic [1:0]       inc [NUM_CNT];
  logic [WIDTH-1:0] cnt [NUM_CNT];
  logic [NUM_CNT-1:0] ovf;
  logic             cnt_en, halt_hit;
  logic             br1, br2, jmp1, jmp2, ins1, ins2;
  logic [6:0]       stat7;
  logic [WIDTH-1:0] status;
  int               rd_sel;

  always_comb begin
    ins1 = (bus.instr_d1 != '0) && (bus.instr_d1 != NOP_WORD);
    ins2 = (bus.instr_d2 != '0) && (bus.instr_d2 != NOP_WORD);
    br1  = bus.op_e1 == OP_BRANCH;
    br2  = bus.op_e2 == OP_BRANCH;
    jmp1 = (bus.op_e1 == OP_JAL) || (bus.op_e1 == OP_JALR);
    jmp2 = (bus.op_e2 == OP_JAL) || (bus.op_e2 == OP_JALR);
    inc[CNT_CYCLES]   = 2'd1;
    inc[CNT_INSTRS]   = count2(ins1, ins2);
    inc[CNT_BRANCHES] = count2(br1, br2);
    inc[CNT_BR_MISS]  = count2(br1 & bus.mispredict1, br2 & bus.mispredict2);
    inc[CNT_JUMPS]    = count2(jmp1, jmp2);
    inc[CNT_JMP_MISS] = count2(jmp1 & ~bus.pred_taken1, jmp2 & ~bus.pred_taken2);
  end

  assign cnt_en = bus.en && (state_q == ST_RUN);

  for (genvar i = 0; i < NUM_CNT; i++) begin : g_cnt
    perf_counter #(.WIDTH(WIDTH)) u_cnt (
      .clk   (clk),
      .reset (reset),
      .en    (cnt_en),
      .clr   (bus.clr),
      .inc   (inc[i]),
      .cnt   (cnt[i]),
      .ovf   (ovf[i])
    );
  end

  // Completion: both fetch slots re-fetching the same PC holding a NOP. Independent of en.
  assign halt_hit = prev_valid_q
                 && (bus.pc_f1 == prev_pc1_q) && (bus.pc_f2 == prev_pc2_q)
                 && (bus.instr_f1 == NOP_WORD) && (bus.instr_f2 == NOP_WORD);

  assign stat7 = {ovf, state_q == ST_HALTED};
  if (WIDTH > 7) begin : g_stat_pad
    assign status = {{(WIDTH - 7){1'b0}}, stat7};
  end else if (WIDTH == 7) begin : g_stat_full
    assign status = stat7;
  end else begin : g_stat_trunc
    assign status = stat7[WIDTH-1:0];
  end

  always_comb begin
    state_d      = state_q;
    prev_valid_d = !bus.clr;
    prev_pc1_d   = bus.pc_f1;
    prev_pc2_d   = bus.pc_f2;
    rd_valid_d   = bus.rd_req;
    rd_data_d    = rd_data_q;
    rd_sel       = int'(bus.rd_addr);
    if (bus.clr) begin
      state_d = ST_RUN;
    end else if (state_q == ST_RUN && halt_hit) begin
      state_d = ST_HALTED;
    end
    // Counter outputs are the pre-increment (and pre-clear) values for this edge.
    if (bus.rd_req) begin
      case (rd_sel)
        CNT_CYCLES:   rd_data_d = cnt[CNT_CYCLES];
        CNT_INSTRS:   rd_data_d = cnt[CNT_INSTRS];
        CNT_BRANCHES: rd_data_d = cnt[CNT_BRANCHES];
        CNT_BR_MISS:  rd_data_d = cnt[CNT_BR_MISS];
        CNT_JUMPS:    rd_data_d = cnt[CNT_JUMPS];
        CNT_JMP_MISS: rd_data_d = cnt[CNT_JMP_MISS];
        CNT_STATUS:   rd_data_d = status;
        default:      rd_data_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= ST_RUN;
      prev_valid_q <= 1'b0;
      rd_valid_q   <= 1'b0;
      rd_data_q    <= '0;
    end else begin
      state_q      <= state_d;
      prev_valid_q <= prev_valid_d;
      rd_valid_q   <= rd_valid_d;
      rd_data_q    <= rd_data_d;
    end
  end

  // Fetch PCs are tracked every cycle, including under reset; prev_valid gates their use.
  always_ff @(posedge clk) begin
    prev_pc1_q <= prev_pc1_d;
    prev_pc2_q <= prev_pc2_d;
  end

  assign bus.rd_valid = rd_valid_q;
  assign bus.rd_data  = rd_data_q;
  assign bus.halted   = (state_q == ST_HALTED);

endmodule

// File: tb/tb_superscalar_perf_monitor.sv
// Scoreboard bench: directed stimulus pushes expected reads/probes; a negedge monitor checks them.
module tb_superscalar_perf_monitor;

  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam logic [31:0] ADDI = 32'h0050_0093;
`ifdef PERF_SATURATE_EN
  localparam logic [31:0] W4_INSTR_EXP = 32'd15;
`else
  localparam logic [31:0] W4_INSTR_EXP = 32'd0;
`endif

  typedef struct {
    logic [31:0] exp;
    string       name;
  } rexp_t;

  typedef struct {
    int          kind;   // 0 halted, 1 rd_valid, 2 rd_data
    logic [31:0] exp;
    string       name;
  } probe_t;

  logic clk = 1'b0;
  logic reset, reset4;
  logic done = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  rexp_t  rq[$];
  rexp_t  rq4[$];
  probe_t pq[$];

  always #5 clk = ~clk;

  superscalar_perf_monitor_if #(.WIDTH(32)) bus ();
  superscalar_perf_monitor_if #(.WIDTH(4))  bus4 ();

  superscalar_perf_monitor #(.WIDTH(32), .NOP_WORD(NOP)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  superscalar_perf_monitor #(.WIDTH(4), .NOP_WORD(NOP)) dut4 (
    .clk   (clk),
    .reset (reset4),
    .bus   (bus4)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [2:0] a, input logic [31:0] e, input string n);
    bus.rd_req  = 1'b1;
    bus.rd_addr = a;
    rq.push_back('{exp: e, name: n});
    step();
    bus.rd_req = 1'b0;
  endtask

  task automatic rd4(input logic [2:0] a, input logic [31:0] e, input string n);
    bus4.rd_req  = 1'b1;
    bus4.rd_addr = a;
    rq4.push_back('{exp: e, name: n});
    step();
    bus4.rd_req = 1'b0;
  endtask

  task automatic probe(input int k, input logic [31:0] e, input string n);
    pq.push_back('{kind: k, exp: e, name: n});
  endtask

  // Monitor: the only process that counts comparisons.
  always @(negedge clk) begin : mon
    probe_t      p;
    rexp_t       r;
    logic [31:0] act;
    cyc++;
    while (pq.size() > 0) begin
      p = pq.pop_front();
      case (p.kind)
        0:       act = {31'b0, bus.halted};
        1:       act = {31'b0, bus.rd_valid};
        default: act = bus.rd_data;
      endcase
      checks++;
      if (act !== p.exp) begin
        errors++;
        $display("FAIL %s got %0h want %0h", p.name, act, p.exp);
      end
    end
    if (bus.rd_valid) begin
      checks++;
      if (rq.size() == 0) begin
        errors++;
        $display("FAIL unexpected_rd_valid got data %0h want no read", bus.rd_data);
      end else begin
        r = rq.pop_front();
        if (bus.rd_data !== r.exp) begin
          errors++;
          $display("FAIL %s got %0d want %0d", r.name, bus.rd_data, r.exp);
        end
      end
    end
    if (bus4.rd_valid) begin
      checks++;
      if (rq4.size() == 0) begin
        errors++;
        $display("FAIL unexpected_rd_valid_w4 got data %0h want no read", bus4.rd_data);
      end else begin
        r = rq4.pop_front();
        if ({28'b0, bus4.rd_data} !== r.exp) begin
          errors++;
          $display("FAIL %s got %0d want %0d", r.name, bus4.rd_data, r.exp);
        end
      end
    end
    if (done || cyc > 20000) begin
      if (!done) begin
        checks++;
        errors++;
        $display("FAIL watchdog got %0d cycles want stimulus done", cyc);
      end
      while (rq.size() > 0) begin
        r = rq.pop_front();
        checks++;
        errors++;
        $display("FAIL %s got no rd_valid want %0d", r.name, r.exp);
      end
      while (rq4.size() > 0) begin
        r = rq4.pop_front();
        checks++;
        errors++;
        $display("FAIL %s got no rd_valid want %0d", r.name, r.exp);
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
    end
  end

  task automatic idle_bus();
    bus.en = 1'b0;          bus.clr = 1'b0;
    bus.instr_d1 = '0;      bus.instr_d2 = '0;
    bus.op_e1 = '0;         bus.op_e2 = '0;
    bus.mispredict1 = 1'b0; bus.mispredict2 = 1'b0;
    bus.pred_taken1 = 1'b0; bus.pred_taken2 = 1'b0;
    bus.pc_f1 = '0;         bus.pc_f2 = '0;
    bus.instr_f1 = '0;      bus.instr_f2 = '0;
    bus.rd_req = 1'b0;      bus.rd_addr = '0;
    bus4.en = 1'b0;          bus4.clr = 1'b0;
    bus4.instr_d1 = '0;      bus4.instr_d2 = '0;
    bus4.op_e1 = '0;         bus4.op_e2 = '0;
    bus4.mispredict1 = 1'b0; bus4.mispredict2 = 1'b0;
    bus4.pred_taken1 = 1'b0; bus4.pred_taken2 = 1'b0;
    bus4.pc_f1 = '0;         bus4.pc_f2 = '0;
    bus4.instr_f1 = '0;      bus4.instr_f2 = '0;
    bus4.rd_req = 1'b0;      bus4.rd_addr = '0;
  endtask

  initial begin
    reset  = 1'b0;
    reset4 = 1'b0;
    idle_bus();
    repeat (3) step();
    probe(0, 0, "rst_halted");
    probe(1, 0, "rst_rd_valid");
    probe(2, 0, "rst_rd_data");
    reset  = 1'b1;
    reset4 = 1'b1;
    rd(3'd0, 0, "rst_cycles");
    rd(3'd6, 0, "rst_status");

    // 10 cycles of dual-issue ADDI
    bus.instr_d1 = ADDI; bus.instr_d2 = ADDI; bus.en = 1'b1;
    repeat (10) step();
    bus.en = 1'b0;
    rd(3'd0, 10, "t1_cycles");
    rd(3'd1, 20, "t1_instrs");

    // branches then jumps
    bus.instr_d1 = '0; bus.instr_d2 = '0;
    bus.op_e1 = 7'b1100011; bus.op_e2 = 7'b1100011; bus.mispredict1 = 1'b1; bus.en = 1'b1;
    step();
    bus.op_e1 = 7'b1101111; bus.pred_taken1 = 1'b0;
    bus.op_e2 = 7'b1100111; bus.pred_taken2 = 1'b1; bus.mispredict1 = 1'b0;
    step();
    bus.en = 1'b0; bus.op_e1 = '0; bus.op_e2 = '0; bus.pred_taken2 = 1'b0;
    rd(3'd0, 12, "t2_cycles");
    rd(3'd1, 20, "t2_instrs");
    rd(3'd2, 2,  "t2_branches");
    rd(3'd3, 1,  "t2_br_miss");
    rd(3'd4, 2,  "t2_jumps");
    rd(3'd5, 1,  "t2_jmp_miss");
    rd(3'd7, 0,  "t2_addr7");

    // back-to-back reads while counting return the pre-increment value
    bus.en = 1'b1; bus.rd_req = 1'b1; bus.rd_addr = 3'd0;
    rq.push_back('{exp: 12, name: "b2b_first"});
    step();
    rq.push_back('{exp: 13, name: "b2b_second"});
    step();
    bus.rd_req = 1'b0; bus.en = 1'b0;

    // parked fetch on NOP -> halt
    bus.pc_f1 = 32'h40; bus.pc_f2 = 32'h44; bus.instr_f1 = NOP; bus.instr_f2 = NOP; bus.en = 1'b1;
    step();
    probe(0, 0, "halt_first_cycle");
    step();
    probe(0, 1, "halt_detect");
    repeat (3) step();
    rd(3'd0, 16, "halt_cycles_frozen");
    rd(3'd6, 1,  "halt_status");

    // clr with a coincident read returns the pre-clear value
    bus.clr = 1'b1; bus.instr_f1 = '0; bus.instr_f2 = '0; bus.pc_f1 = '0; bus.pc_f2 = '0;
    bus.rd_req = 1'b1; bus.rd_addr = 3'd0;
    rq.push_back('{exp: 16, name: "clr_read_preclear"});
    step();
    bus.clr = 1'b0; bus.rd_req = 1'b0; bus.en = 1'b0;
    probe(0, 0, "clr_halted");
    for (int a = 0; a < 7; a++) rd(3'(a), 0, $sformatf("clr_cnt%0d", a));

    // en low amid traffic: counts hold, halt still detected
    bus.instr_d1 = ADDI; bus.instr_d2 = ADDI;
    bus.op_e1 = 7'b1100011; bus.op_e2 = 7'b1100011; bus.en = 1'b1;
    repeat (3) step();
    bus.en = 1'b0;
    bus.pc_f1 = 32'h80; bus.pc_f2 = 32'h84; bus.instr_f1 = NOP; bus.instr_f2 = NOP;
    step();
    probe(0, 0, "en0_halt_first");
    step();
    probe(0, 1, "en0_halt_detect");
    repeat (3) step();
    bus.en = 1'b1;
    repeat (2) step();
    bus.en = 1'b0;
    rd(3'd0, 3, "en0_cycles");
    rd(3'd1, 6, "en0_instrs");
    rd(3'd2, 6, "en0_branches");
    rd(3'd3, 0, "en0_br_miss");
    rd(3'd6, 1, "en0_status");
    bus.op_e1 = '0; bus.op_e2 = '0;

    // reset on the same edge as a read and a non-zero increment
    bus.pc_f1 = 32'h100; bus.pc_f2 = 32'h104;
    bus.en = 1'b1; bus.rd_req = 1'b1; bus.rd_addr = 3'd1; reset = 1'b0;
    step();
    probe(1, 0, "rst_mid_read_valid");
    reset = 1'b1; bus.rd_req = 1'b0; bus.en = 1'b0;
    step();
    probe(0, 0, "post_rst_no_halt");
    step();
    probe(0, 1, "post_rst_halt_second");
    rd(3'd0, 0, "post_rst_cycles");
    rd(3'd1, 0, "post_rst_instrs");
    rd(3'd2, 0, "post_rst_branches");
    rd(3'd6, 1, "post_rst_status");

    // narrow build: INSTRS 14 then +2
    bus4.instr_d1 = ADDI; bus4.instr_d2 = ADDI; bus4.en = 1'b1;
    repeat (7) step();
    bus4.en = 1'b0;
    rd4(3'd1, 14, "w4_instrs_14");
    bus4.en = 1'b1;
    step();
    bus4.en = 1'b0;
    rd4(3'd1, W4_INSTR_EXP, "w4_instrs_ovf");
    rd4(3'd6, 4, "w4_status_ovf1");
    rd4(3'd0, 8, "w4_cycles");

    repeat (2) step();
    done = 1'b1;
    forever step();
  end

endmodule
